vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Consumes the 108 MHz pixel clock and the lock indication from the VGA PLL.
- Generates 1280x1024@60 Hz raster timing and issues per-pixel coordinate requests to an upstream pixel source.
- Realigns returned pixel data with delayed sync/blank, driving the VGA DAC pins.
- Holds the raster idle until the PLL is locked and stable; restarts cleanly at (0,0) after any loss of lock.

Parameters:
H_ACT, 1280, visible pixels per line
H_FP, 48, horizontal front porch (clocks)
H_SYNC, 112, hsync width (clocks)
H_BP, 248, horizontal back porch (clocks); H_TOTAL = sum = 1688
V_ACT, 1024, visible lines
V_FP, 1, vertical front porch (lines)
V_SYNC, 3, vsync width (lines)
V_BP, 38, vertical back porch (lines); V_TOTAL = sum = 1066
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
PIX_LAT, 2, upstream pixel return latency in clocks, legal 1..8
SETTLE_CYC, 1024, clocks of continuous lock required before raster starts

Ports:
clk  in  1  pixel clock (PLL outclk_0)
rst_n  in  1  synchronous active-low reset
pll_locked  in  1  PLL lock, asynchronous to clk
req_valid  out  1  pixel request, high for active-area positions
req_x  out  11  requested column 0..H_ACT-1
req_y  out  11  requested row 0..V_ACT-1
frame_start  out  1  one-clock pulse coincident with request (0,0)
pix_r, pix_g, pix_b  in  8 each  pixel data, valid PIX_LAT clocks after req_valid
vga_r, vga_g, vga_b  out  8 each  DAC colour, zero outside active area
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_blank_n  out  1  high in active area (DAC blank, active-low)
running  out  1  high while in RUN

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low. All flops clear when rst_n=0 at a clk edge.
- Reset values: req_valid=0, req_x=0, req_y=0, frame_start=0, vga_rgb=0, vga_blank_n=0, vga_hs=~HS_POL, vga_vs=~VS_POL, running=0. Counters 0. FSM in WAIT_LOCK. Delay line filled with inactive values.
- Lock synchroniser: pll_locked goes through a 2-flop synchroniser (lock_s).
- FSM:
  - WAIT_LOCK: lock_s=1 -> SETTLE, clearing settle counter.
  - SETTLE: counts while lock_s=1; on count reaching SETTLE_CYC-1 -> RUN.
  - RUN: running=1.
  - lock_s=0 in any state -> WAIT_LOCK next clock. h_cnt and v_cnt clear, req outputs go 0, delay line flushed to inactive. Outputs reach reset values within PIX_LAT+2 clocks.
- Counters (RUN only):
  - h_cnt 0..H_TOTAL-1 increments every clock and wraps to 0.
  - v_cnt increments when h_cnt wraps, and itself wraps at V_TOTAL-1 -> 0.
  - Widths are 11 bits each.
- Request stage (registered, 1 clock after counter value):
  - req_valid = (h<H_ACT && v<V_ACT).
  - req_x=h, req_y=v when valid; otherwise hold 0.
  - frame_start = (h==0 && v==0).
- Sync decode on the same counter value:
  - hs active for H_ACT+H_FP <= h < H_ACT+H_FP+H_SYNC.
  - vs active for V_ACT+V_FP <= v < V_ACT+V_FP+V_SYNC. vs changes on hs-independent line boundaries, at h==0.
- Output alignment:
  - de/hs/vs go through a PIX_LAT+1 deep shift register.
  - pix_* are registered on the clock they are valid.
  - Request issued in cycle t -> vga_* reflect it in cycle t+PIX_LAT+1.
  - vga_rgb = blank_n ? registered pix : 0. pix_* are ignored when not expected.
- The upstream source has no backpressure. pix_* must be valid exactly PIX_LAT clocks after each req_valid.
- rst_n has priority over lock loss. Reset mid-frame -> reset values on the next clock. Restart requires the full SETTLE period.

Test Plan:
- rst_n low 4 clocks, pll_locked=1 constant -> running rises 2+SETTLE_CYC clocks after release (±1). The first req_valid carries (0,0) with frame_start=1.
- Default timing, one line -> vga_hs period 1688 clocks, active width 112. vga_blank_n high 1280 clocks per active line. Active level starts 1328 clocks after blank_n rises.
- Full frame -> 1024 lines with req_valid. vga_vs high 3 lines starting line 1025. Next frame_start exactly 1688*1066 = 1799408 clocks after the previous one.
- PIX_LAT=2; pix_r = req_x[7:0], pix_g = req_y[7:0], returned 2 clocks later -> vga_r equals column low byte 3 clocks after request. vga_rgb=0 throughout blanking.
- Deassert pll_locked at (500,300) -> running=0 within 3 clocks, all outputs at reset values by PIX_LAT+2 clocks. Reassert -> after settle, raster restarts at (0,0) with frame_start.
- rst_n low for 1 clock mid-line with lock held -> next clock all outputs at reset values, FSM in WAIT_LOCK, then resumes via SETTLE.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 1280x1024@60 raster timing, pixel requests and sync/blank realignment for the VGA DAC
module vga_timing_gen #(
  parameter int   H_ACT      = 1280,
  parameter int   H_FP       = 48,
  parameter int   H_SYNC     = 112,
  parameter int   H_BP       = 248,
  parameter int   V_ACT      = 1024,
  parameter int   V_FP       = 1,
  parameter int   V_SYNC     = 3,
  parameter int   V_BP       = 38,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   PIX_LAT    = 2,
  parameter int   SETTLE_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        req_valid,
  output logic [10:0] req_x,
  output logic [10:0] req_y,
  output logic        frame_start,
  input  logic [7:0]  pix_r,
  input  logic [7:0]  pix_g,
  input  logic [7:0]  pix_b,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        running
);
  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int D = PIX_LAT + 2;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_A    = 11'(H_ACT);
  localparam logic [10:0] V_A    = 11'(V_ACT);
  localparam logic [10:0] HS_B   = 11'(H_ACT + H_FP);
  localparam logic [10:0] HS_E   = 11'(H_ACT + H_FP + H_SYNC);
  localparam logic [10:0] VS_B   = 11'(V_ACT + V_FP);
  localparam logic [10:0] VS_E   = 11'(V_ACT + V_FP + V_SYNC);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t        state_q;
  logic [SW-1:0] settle_q;
  logic          lock_m_q, lock_s_q, running_q;
  logic [10:0]   h_q, v_q, h_d, v_d;
  logic          run, act, hs_act, vs_act;
  logic          req_valid_q, frame_start_q;
  logic [10:0]   req_x_q, req_y_q;
  logic [D-1:0]  de_q, hs_q, vs_q;
  logic [23:0]   rgb_q;

  // bring the asynchronous PLL lock into the pixel clock domain
  always_ff @(posedge clk) begin
    if (!rst_n) {lock_s_q, lock_m_q} <= 2'b00;
    else {lock_s_q, lock_m_q} <= {lock_m_q, pll_locked};
  end

  // lock supervisor: any lock drop restarts the full settle period
  always_ff @(posedge clk) begin
    if (!rst_n || !lock_s_q) begin
      state_q   <= WAIT_LOCK;
      settle_q  <= '0;
      running_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          state_q  <= SETTLE;
          settle_q <= '0;
        end
        SETTLE: begin
          if (settle_q == S_LAST) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end else settle_q <= settle_q + 1'b1;
        end
        default: running_q <= 1'b1;
      endcase
    end
  end

  assign run = (state_q == RUN) && lock_s_q;

  // raster counters and decode of the current position
  always_comb begin
    h_d    = !run ? '0 : (h_q == H_LAST ? '0 : h_q + 11'd1);
    v_d    = !run ? '0 : (h_q != H_LAST ? v_q : (v_q == V_LAST ? '0 : v_q + 11'd1));
    act    = run && (h_q < H_A) && (v_q < V_A);
    hs_act = run && (h_q >= HS_B) && (h_q < HS_E);
    vs_act = run && (v_q >= VS_B) && (v_q < VS_E);
  end

  // counters, request stage and the sync/blank delay line matching the pixel return path
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      req_valid_q   <= 1'b0;
      req_x_q       <= '0;
      req_y_q       <= '0;
      frame_start_q <= 1'b0;
      de_q          <= '0;
      hs_q          <= '0;
      vs_q          <= '0;
      rgb_q         <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      req_valid_q   <= act;
      req_x_q       <= act ? h_q : '0;
      req_y_q       <= act ? v_q : '0;
      frame_start_q <= run && (h_q == '0) && (v_q == '0);
      de_q          <= run ? {de_q[D-2:0], act} : '0;
      hs_q          <= run ? {hs_q[D-2:0], hs_act} : '0;
      vs_q          <= run ? {vs_q[D-2:0], vs_act} : '0;
      rgb_q         <= (run && de_q[PIX_LAT]) ? {pix_r, pix_g, pix_b} : '0;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign frame_start = frame_start_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  assign vga_blank_n = de_q[D-1];
  assign vga_hs      = hs_q[D-1] ? HS_POL : !HS_POL;
  assign vga_vs      = vs_q[D-1] ? VS_POL : !VS_POL;
  assign running     = running_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scaled raster with a pixel-source model and a return-data scoreboard
module tb_vga_timing_gen;
  localparam int HA = 16, HF = 2, HSY = 3, HB = 4, HT = HA + HF + HSY + HB;
  localparam int VA = 6, VF = 1, VSY = 2, VB = 2, VT = VA + VF + VSY + VB;
  localparam int PL = 2, S = 20, FRAME = HT * VT, LIM = 4 * FRAME;
  localparam logic HS_POL = 1'b1, VS_POL = 1'b1;
  localparam int SIG_HS = 0, SIG_BL = 1, SIG_FS = 3, SIG_RUN = 4, SIG_RV = 5;

  logic clk, rst_n, pll_locked, req_valid, frame_start, vga_hs, vga_vs, vga_blank_n, running;
  logic [10:0] req_x, req_y;
  logic [7:0] pix_r, pix_g, pix_b, vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HS_POL), .VS_POL(VS_POL), .PIX_LAT(PL), .SETTLE_CYC(S)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .frame_start(frame_start),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int due; logic [23:0] rgb; } exp_t;
  typedef struct { string name; logic rst_n; logic lock; int cycles; logic exp_run; logic exp_blank; } step_t;

  exp_t        q[$];
  step_t       steps[4];
  logic [16:0] pend[0:PL];
  int total = 0, bad = 0, cyc = 0, ex = 0, ey = 0;
  logic sb_en = 1'b0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic chk_rng(input string n, input int a, input int lo, input int hi);
    total++;
    if (a < lo || a > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", n, a, lo, hi);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int s);
    case (s)
      SIG_HS:  return vga_hs == HS_POL;
      SIG_BL:  return vga_blank_n;
      SIG_FS:  return frame_start;
      SIG_RUN: return running;
      default: return req_valid;
    endcase
  endfunction

  task automatic wait_sig(input int s, input logic v, output int n);
    n = 0;
    while (sig(s) !== v && n < LIM) begin
      step();
      n++;
    end
    if (sig(s) !== v) begin
      total++;
      bad++;
      $display("FAIL wait_sig%0d: still %b want %b after %0d clocks", s, sig(s), v, n);
    end
  endtask

  task automatic wait_req(input int x, input int y);
    int n = 0;
    while (!(req_valid && req_x == x && req_y == y) && n < LIM) begin
      step();
      n++;
    end
    chk("wait_req", {req_valid, 5'd0, req_x, 4'd0, req_y}, {1'b1, 5'd0, 11'(x), 4'd0, 11'(y)});
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_req_valid"}, req_valid, 0);
    chk({t, "_req_xy"}, {req_x, req_y}, 0);
    chk({t, "_frame_start"}, frame_start, 0);
    chk({t, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({t, "_blank_n"}, vga_blank_n, 0);
    chk({t, "_hs"}, vga_hs, !HS_POL);
    chk({t, "_vs"}, vga_vs, !VS_POL);
    chk({t, "_running"}, running, 0);
  endtask

  task automatic run_rise(input string t);
    int n = 0;
    while (!running && n < LIM) begin
      step();
      n++;
    end
    chk_rng({t, "_run_rise"}, n, 2 + S - 1, 2 + S + 1);
  endtask

  task automatic first_req(input string t);
    int n;
    wait_sig(SIG_RV, 1'b1, n);
    chk({t, "_first_xy"}, {req_x, req_y}, 0);
    chk({t, "_first_fs"}, frame_start, 1);
  endtask

  // raster-order checker, upstream pixel source and return-data scoreboard
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb_en) begin
      if (req_valid) begin
        chk("req_x", req_x, ex);
        chk("req_y", req_y, ey);
        chk("req_fs", frame_start, (ex == 0 && ey == 0));
        q.push_back('{cyc + PL + 1, {req_x[7:0], req_y[7:0], req_x[7:0] ^ req_y[7:0]}});
        if (ex == HA - 1) begin
          ex = 0;
          ey = (ey == VA - 1) ? 0 : ey + 1;
        end else ex++;
      end else chk("req_idle", {frame_start, req_x, req_y}, 0);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("vga_rgb", {vga_r, vga_g, vga_b}, e.rgb);
        chk("vga_blank_n", vga_blank_n, 1);
      end else chk("blanked", {vga_blank_n, vga_r, vga_g, vga_b}, 0);
    end
    for (int i = PL; i > 0; i--) pend[i] = pend[i-1];
    pend[0] = {req_valid, req_x[7:0], req_y[7:0]};
    {pix_r, pix_g, pix_b} = pend[PL][16] ?
      {pend[PL][15:8], pend[PL][7:0], pend[PL][15:8] ^ pend[PL][7:0]} : 24'($urandom);
  end

  initial begin
    int n, w, r, d, reqs, vsn, vs_first, fall;
    for (int i = 0; i <= PL; i++) pend[i] = '0;
    rst_n = 1'b0;
    pll_locked = 1'b1;
    {pix_r, pix_g, pix_b} = '0;
    steps[0] = '{"reset",        1'b0, 1'b1, 4,  1'b0, 1'b0};
    steps[1] = '{"no_lock",      1'b1, 1'b0, 30, 1'b0, 1'b0};
    steps[2] = '{"settle_early", 1'b1, 1'b1, S,  1'b0, 1'b0};
    steps[3] = '{"settle_done",  1'b1, 1'b1, 4,  1'b1, 1'b0};
    for (int k = 0; k < 4; k++) begin
      rst_n = steps[k].rst_n;
      pll_locked = steps[k].lock;
      repeat (steps[k].cycles) step();
      chk({steps[k].name, "_running"}, running, steps[k].exp_run);
      chk({steps[k].name, "_blank_n"}, vga_blank_n, steps[k].exp_blank);
      if (k == 0) begin
        chk_reset("reset");
        sb_en = 1'b1;
      end
    end

    wait_sig(SIG_HS, 1'b0, n);
    wait_sig(SIG_HS, 1'b1, n);
    wait_sig(SIG_HS, 1'b0, w);
    wait_sig(SIG_HS, 1'b1, r);
    chk("hs_width", w, HSY);
    chk("hs_period", w + r, HT);
    wait_sig(SIG_BL, 1'b0, n);
    wait_sig(SIG_BL, 1'b1, n);
    wait_sig(SIG_BL, 1'b0, w);
    wait_sig(SIG_HS, 1'b1, d);
    chk("blank_width", w, HA);
    chk("blank_to_hs", w + d, HA + HF);

    wait_sig(SIG_FS, 1'b1, n);
    reqs = 0;
    vsn = 0;
    vs_first = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (req_valid) reqs++;
      if (vga_vs == VS_POL) begin
        vsn++;
        if (vs_first < 0) vs_first = i;
      end
      step();
    end
    chk("frame_period_fs", frame_start, 1);
    chk("frame_reqs", reqs, HA * VA);
    chk("vs_clocks", vsn, VSY * HT);
    chk("vs_start", vs_first, (VA + VF) * HT + PL + 1);

    wait_req(10, 3);
    pll_locked = 1'b0;
    sb_en = 1'b0;
    q.delete();
    fall = 0;
    for (int i = 1; i <= PL + 2; i++) begin
      step();
      if (!running && fall == 0) fall = i;
    end
    chk_rng("lockloss_run_fall", fall, 1, 3);
    chk_reset("lockloss");
    repeat (5) step();
    pll_locked = 1'b1;
    ex = 0;
    ey = 0;
    sb_en = 1'b1;
    run_rise("relock");
    first_req("relock");

    wait_req(5, 1);
    rst_n = 1'b0;
    sb_en = 1'b0;
    q.delete();
    step();
    chk_reset("rst_mid");
    rst_n = 1'b1;
    ex = 0;
    ey = 0;
    sb_en = 1'b1;
    run_rise("rst_mid");
    first_req("rst_mid");
    repeat (FRAME + 10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
